nibble_add_seq: RTL and testbench
=================================

# nibble_add_seq

- Multi-cycle adder controller that computes a WIDTH-bit sum one 4-bit nibble per cycle.
- Reuses a single 4-bit ripple slice and carries between nibbles in a register.
- Accepts operands over a valid/ready input handshake and returns the result over a valid/ready output handshake.
- Sits between the operand source and result consumer, trading latency for area versus a full-width adder.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, minimum 8. NIB = WIDTH/4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept; equals (state == IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in to nibble 0.
- sub  in  1  subtract request; present only with NIBBLE_ADD_SUB_EN.
- out_valid  out  1  result held; equals (state == DONE).
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  registered result.
- c_out  out  1  carry out of the MSB nibble.
- overflow  out  1  two's-complement overflow.

Reset is asynchronous, active-low on rst_n; single clock clk.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, on in_valid:
  - Register a into a_q and the effective B into b_q. Without subtract, effective B is b.
  - Load carry_q <= c_in and idx <= 0, then go to RUN.
  - in_valid outside IDLE is ignored; operand changes after capture have no effect.
- RUN:
  - The slice adds a_q[4*idx+:4] + b_q[4*idx+:4] + carry_q.
  - sum[4*idx+:4] <= slice sum; carry_q <= slice carry; idx <= idx+1.
  - When idx == NIB-1: c_out <= slice carry, overflow is computed, go to DONE.
- overflow = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]). It uses the effective B.
- DONE:
  - sum, c_out and overflow are held stable.
  - out_ready high: go to IDLE on that edge. sum/c_out/overflow keep their values until the next capture; they are valid only while out_valid.
- sum nibbles not yet written in RUN keep their previous-result values. The consumer only samples when out_valid is high.
- Reset (at any time, including mid-RUN or in DONE):
  - State goes to IDLE; all registers clear: sum=0, c_out=0, overflow=0, idx=0, carry_q=0.
  - Outputs during reset: out_valid=0, in_ready=1.
  - An aborted operation produces no out_valid.

## Timing
- Capture edge E (in_valid && in_ready).
- Nibble k (0..NIB-1) is written at edge E+1+k.
- out_valid rises after edge E+NIB: latency NIB cycles from capture (4 for WIDTH=16).
- Minimum initiation interval is NIB+2 cycles: capture, NIB RUN cycles, DONE for at least 1 cycle, back to IDLE.
- in_ready is low for the full RUN and DONE period; there is no same-cycle DONE→capture.
- in_ready and out_valid are purely state-decoded and carry no combinational path from inputs.

## Configuration
- NIBBLE_ADD_SUB_EN defined:
  - The sub port exists.
  - At capture with sub=1: b_q <= ~b and carry_q <= 1; c_in is ignored.
  - c_out is then the "no borrow" flag.
- NIBBLE_ADD_SUB_EN undefined:
  - No sub port; add only.
  - All other behaviour is identical.

## Structure
- Package nibble_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  - localparam NIB_W = 4.
- Sub-module nibble_add4: purely combinational 4-bit ripple slice.
  - Ports: a[3:0], b[3:0], c_in → sum[3:0], c_out.
  - Instantiated once; the controller muxes nibbles into it by idx.

## Test plan
- a=0x1234, b=0x0FCD, c_in=0 → sum=0x2201, c_out=0, overflow=0; out_valid exactly 4 cycles after capture.
- a=0xFFFF, b=0x0001 → sum=0x0000, c_out=1, overflow=0. Carry ripples through every nibble boundary.
- a=0x7FFF, b=0x0001 → sum=0x8000, overflow=1, c_out=0. Also a=0x8000, b=0x8000 → sum=0x0000, c_out=1, overflow=1 (checks MSB-slice carry).
- With NIBBLE_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0, overflow=0. sub=1, a=0x0007, b=0x0005 → sum=0x0002, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands. Result stays stable and in_ready stays 0; after out_ready=1, state returns to IDLE and the new operands are captured next cycle.
- Assert rst_n low 2 cycles into RUN → in_ready=1 and out_valid=0 immediately, sum=0. out_valid never rises for the aborted operation; the next operation completes normally.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional feature macro used by this codebase slice: NIBBLE_ADD_SUB_EN.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit ripple-carry slice, reused once per nibble.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] c;

  // Ripple the carry bit by bit through the four full adders.
  always_comb begin
    c    = 5'd0;
    sum  = 4'd0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[4];
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle adder: computes a WIDTH-bit sum one nibble per clock through a
// single 4-bit ripple slice, with valid/ready handshakes on both sides.
// Optional subtract support is compiled in when NIBBLE_ADD_SUB_EN is defined.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] b_eff;
  logic             carry_init;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_c;

  // Handshake flags decode the state register only, never the inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Select the effective B operand and initial carry captured with the operands.
  always_comb begin
    b_eff      = b;
    carry_init = c_in;
`ifdef NIBBLE_ADD_SUB_EN
    if (sub) begin
      b_eff      = ~b;
      carry_init = 1'b1;
    end else begin
      b_eff      = b;
      carry_init = c_in;
    end
`endif
  end

  // Route the current nibble of each captured operand into the shared slice.
  assign a_nib = a_q[NIB_W*idx +: NIB_W];
  assign b_nib = b_q[NIB_W*idx +: NIB_W];

  nibble_add4 u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_c)
  );

  // Controller FSM: capture operands, step through nibbles, hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      idx      <= {IDX_W{1'b0}};
      sum      <= {WIDTH{1'b0}};
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= carry_init;
            idx     <= {IDX_W{1'b0}};
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          sum[NIB_W*idx +: NIB_W] <= slice_sum;
          carry_q                 <= slice_c;
          if (idx == LAST_IDX) begin
            c_out    <= slice_c;
            overflow <= ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], slice_sum[NIB_W-1]);
            idx      <= {IDX_W{1'b0}};
            state    <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            state    <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: directed vector table, randomized
// operations against an arithmetic reference model, backpressure and
// mid-operation reset sequences. Subtract vectors run when NIBBLE_ADD_SUB_EN
// is defined.
module tb_nibble_add_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[$];

  nibble_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef NIBBLE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference model: plain full-width arithmetic on the effective operands.
  function automatic vec_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vcin, input logic vsub);
    vec_t r;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] beff;
    logic             ceff;
    beff = vsub ? ~vb : vb;
    ceff = vsub ? 1'b1 : vcin;
    full = {1'b0, va} + {1'b0, beff} + {{WIDTH{1'b0}}, ceff};
    r.a = va; r.b = vb; r.cin = vcin; r.sub = vsub;
    r.exp_sum  = full[WIDTH-1:0];
    r.exp_cout = full[WIDTH];
    r.exp_ovf  = (va[WIDTH-1] == beff[WIDTH-1]) && (full[WIDTH-1] != va[WIDTH-1]);
    return r;
  endfunction

  function automatic vec_t mk(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                              input logic vcin, input logic vsub, input logic [WIDTH-1:0] s,
                              input logic co, input logic ov);
    vec_t r;
    r.a = va; r.b = vb; r.cin = vcin; r.sub = vsub;
    r.exp_sum = s; r.exp_cout = co; r.exp_ovf = ov;
    return r;
  endfunction

  // Count edges after capture until out_valid, noting any in_ready while busy.
  task automatic wait_done(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (out_valid) break;
      if (in_ready) saw_ready = 1'b1;
    end
  endtask

  // One complete transaction: wait idle, capture, scramble inputs, check, release.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    bit saw;
    lat = 0;
    while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    a = v.a; b = v.b; c_in = v.cin; sub = v.sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    wait_done(lat, saw);
    check({nm, "_latency"}, 32'(lat), 32'(NIB));
    check({nm, "_sum"}, 32'(sum), 32'(v.exp_sum));
    check({nm, "_cout"}, 32'(c_out), 32'(v.exp_cout));
    check({nm, "_ovf"}, 32'(overflow), 32'(v.exp_ovf));
    check({nm, "_busy_ready"}, 32'(saw), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    bit saw;
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;

    vecs.push_back(mk(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
    vecs.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
    vecs.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1));
    vecs.push_back(mk(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0));
`ifdef NIBBLE_ADD_SUB_EN
    vecs.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0));
    vecs.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout_ovf", {30'd0, c_out, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
`ifdef NIBBLE_ADD_SUB_EN
      v = model(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`else
      v = model(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
`endif
      run_op(v, $sformatf("rnd%0d", i));
    end

    // Backpressure: DONE held while new operands wait on the input side.
    a = 16'h1234; b = 16'h0FCD; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, saw);
    check("bp_latency", 32'(lat), 32'(NIB));
    a = 16'h7FFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_sum%0d", k), 32'(sum), 32'h2201);
      check($sformatf("bp_hold_flags%0d", k), {30'd0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    check("bp_new_captured", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_done(lat, saw);
    check("bp_new_latency", 32'(lat), 32'(NIB));
    check("bp_new_sum", 32'(sum), 32'h8000);
    check("bp_new_flags", {30'd0, c_out, overflow}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset two cycles into RUN aborts the operation.
    a = 16'hFFFF; b = 16'h1111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_partial_sum", 32'(sum[7:0]), 32'h10);
    rst_n = 1'b0;
    #1;
    check("abort_flags", {30'd0, in_ready, out_valid}, 32'd2);
    check("abort_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_valid", 32'(saw), 32'd0);
    run_op(model(16'h4321, 16'h1111, 1'b1, 1'b0), "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
